// File: rtl/rv_ifetch_unit.sv
// Instruction fetch unit: fetch PC, in-order imem requests, response FIFO toward decode, redirect flush.
// Optional misaligned-redirect trap enabled by RV_IFETCH_MISALIGN_CHK_EN.
module rv_ifetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  if_misalign
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
`ifdef RV_IFETCH_MISALIGN_CHK_EN
  localparam logic [1:0] ST_HALT  = 2'd2;
`endif

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]      out_q, out_d, drop_q, drop_d, cnt_q, cnt_d, out_after;
  logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d, pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pcq_mem_q   [FIFO_DEPTH];
  logic [SUM_W-1:0]      occ;
  logic                  req_accept, pop, push;
  logic [ADDR_WIDTH-1:0] push_pc;
  logic [DATA_WIDTH-1:0] push_instr;
`ifdef RV_IFETCH_MISALIGN_CHK_EN
  logic                  mis_mem_q [FIFO_DEPTH];
  logic                  tag_q, tag_d, push_mis;
`endif

  assign if_valid       = (cnt_q != '0);
  assign if_pc          = pc_mem_q[rd_q];
  assign if_instr       = instr_mem_q[rd_q];
  assign imem_req_addr  = fetch_pc_q;
  assign pop            = if_valid && if_ready;
  // An entry popped this cycle frees its slot, which keeps single-cycle memory at full rate.
  assign occ            = SUM_W'(out_q) + SUM_W'(cnt_q) - SUM_W'(pop);
  assign imem_req_valid = (state_q == ST_FETCH) && !redirect_valid && (occ < SUM_W'(FIFO_DEPTH));
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign out_after      = out_q + CNT_W'(req_accept) - CNT_W'(imem_rsp_valid);
`ifdef RV_IFETCH_MISALIGN_CHK_EN
  assign if_misalign    = mis_mem_q[rd_q];
`else
  assign if_misalign    = 1'b0;
`endif

  // Next-state: FSM, counters, pointers and flush
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_after;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_wr_d   = pcq_wr_q;
    push       = 1'b0;
    push_pc    = pcq_mem_q[pcq_rd_q];
    push_instr = imem_rsp_data;
`ifdef RV_IFETCH_MISALIGN_CHK_EN
    tag_d      = tag_q;
    push_mis   = 1'b0;
`endif

    if (state_q == ST_RESET) state_d = ST_FETCH;

    if (req_accept) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      pcq_wr_d   = pcq_wr_q + PTR_W'(1);
    end

    if (imem_rsp_valid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - CNT_W'(1);
      end else begin
        pcq_rd_d = pcq_rd_q + PTR_W'(1);
        push     = 1'b1;
      end
    end

`ifdef RV_IFETCH_MISALIGN_CHK_EN
    // Trap entry posts only after every stale response has drained.
    if ((state_q == ST_HALT) && tag_q && (drop_q == '0) && !imem_rsp_valid) begin
      push       = 1'b1;
      push_pc    = fetch_pc_q;
      push_instr = '0;
      push_mis   = 1'b1;
      tag_d      = 1'b0;
    end
`endif

    if (push) wr_d = wr_q + PTR_W'(1);
    if (pop)  rd_d = rd_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_d     = out_after;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      pcq_rd_d   = '0;
      pcq_wr_d   = '0;
      push       = 1'b0;
`ifdef RV_IFETCH_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = ST_HALT;
        tag_d   = 1'b1;
      end else begin
        state_d = ST_FETCH;
        tag_d   = 1'b0;
      end
`endif
    end
  end

  // State and buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
        pcq_mem_q[i]   <= '0;
`ifdef RV_IFETCH_MISALIGN_CHK_EN
        mis_mem_q[i]   <= 1'b0;
`endif
      end
`ifdef RV_IFETCH_MISALIGN_CHK_EN
      tag_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      if (req_accept) pcq_mem_q[pcq_wr_q] <= imem_req_addr;
      if (push) begin
        pc_mem_q[wr_q]    <= push_pc;
        instr_mem_q[wr_q] <= push_instr;
`ifdef RV_IFETCH_MISALIGN_CHK_EN
        mis_mem_q[wr_q]   <= push_mis;
`endif
      end
`ifdef RV_IFETCH_MISALIGN_CHK_EN
      tag_q      <= tag_d;
`endif
    end
  end

endmodule

// File: doc/rv_ifetch_unit.md
# rv_ifetch_unit

Instruction fetch unit that consumes the next-PC produced by branch/jump resolution and turns it into a stream of instruction-memory reads. Holds the architectural fetch PC, issues in-order requests to instruction memory over a valid/ready channel, buffers returned words with their PCs in a small FIFO, and presents them to decode over a valid/ready channel. A redirect flushes buffered and in-flight fetches and restarts at the supplied target.

## Interface
- ADDR_WIDTH, 32, PC / memory address width
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on in-flight plus buffered fetches (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  redirect target (nextpc from branch resolution)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  fetch address, stable while valid and not ready
- imem_rsp_valid  in  1  response valid; in order, no backpressure, ≥1 cycle after acceptance
- imem_rsp_data  in  DATA_WIDTH  instruction word
- if_valid  out  1  buffered instruction available to decode
- if_ready  in  1  decode accepts
- if_pc  out  ADDR_WIDTH  PC of head instruction
- if_instr  out  DATA_WIDTH  head instruction word
- if_misalign  out  1  head entry tagged misaligned (only with macro, else tied 0)

## Operation
- Registers: fetch_pc, outstanding (0..FIFO_DEPTH), drop_cnt (0..FIFO_DEPTH), FIFO of {pc, instr, misalign}, FSM state.
- FSM: RESET → FETCH (first cycle after rst_n deasserts); FETCH ↔ HALT (macro only). No other states.
- Request rule (FETCH): imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH). Address = fetch_pc. On accept, fetch_pc ← fetch_pc + 4 (wraps mod 2^ADDR_WIDTH), outstanding +1.
- Request PCs queued in a side FIFO of the same depth so each response is paired with its PC.
- Response: outstanding −1. If drop_cnt > 0, discard and drop_cnt −1; else push {pc, data} into FIFO.
- Decode handshake: pop when if_valid && if_ready. Push and pop same cycle allowed when FIFO full (pop frees slot).
- Redirect: fetch_pc ← redirect_pc; FIFO and side-PC queue flushed; drop_cnt ← outstanding after this cycle's accounting (in-flight responses discarded); request suppressed that cycle. A response arriving in the redirect cycle is discarded. A decode handshake in the redirect cycle completes normally (entry already consumed).
- Back-to-back redirects: last one wins; drop_cnt recomputed each time.
- Outstanding never exceeds FIFO_DEPTH, so no response can overflow the FIFO.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, if_valid 0, if_pc 0, if_instr 0, if_misalign 0, fetch_pc RESET_PC, counters 0, FIFO empty.
- First request asserted cycle 1 after reset release.
- Response in cycle N → if_valid in cycle N+1 (registered FIFO, no fall-through).
- Minimum fetch-to-decode latency: accept N, rsp N+1, if_valid N+2.
- Redirect in cycle R → first request to redirect_pc in R+1; if_valid low from R+1 until new data.
- Sustained throughput with single-cycle memory and if_ready=1: one instruction per cycle.

## Configuration
- RV_IFETCH_MISALIGN_CHK_EN defined: redirect_pc[1:0] ≠ 0 moves FSM to HALT; no further requests; a single entry {redirect_pc, 0, misalign=1} is pushed once in-flight drops finish; if_misalign high with it. Only a new aligned redirect leaves HALT (→FETCH); misaligned redirect in HALT stays in HALT and re-posts the tag.
- Undefined: redirect_pc[1:0] ignored for checking, address used as given (low bits passed through), if_misalign tied 0, HALT absent.

## Test plan
- Reset release, 1-cycle memory, if_ready=1 → requests 0x0,0x4,0x8…; if_pc/if_instr stream one per cycle, first if_valid at cycle 3.
- if_ready=0 for 10 cycles → exactly 2 entries buffered, imem_req_valid low, no loss; resume yields PCs 0x0,0x4,0x8 in order.
- imem_req_ready low 5 cycles → imem_req_addr held at 0x8, no PC advance.
- Redirect to 0x100 with 2 fetches in flight → both responses dropped, next if_pc = 0x100, no stale instruction visible.
- Redirect coinciding with response and decode handshake → handshake completes, response dropped, next request 0x100 one cycle later.
- With RV_IFETCH_MISALIGN_CHK_EN: redirect to 0x102 → requests stop, one entry if_pc=0x102 if_misalign=1; redirect to 0x200 resumes fetch.
